serial_frame_rx: RTL and testbench



---
 rtl/serial_rx_pkg.sv | 26 ++
 rtl/serial_frame_rx_timer.sv | 28 ++
 rtl/serial_frame_rx.sv | 147 ++++++++++++++
 tb/tb_serial_frame_rx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial frame receiver.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // data must be zero-extended by the caller so the reduction covers only real bits
  function automatic logic parity_ok(input logic [31:0] data, input logic par_bit,
                                     input int unsigned mode);
    case (mode)
      PARITY_EVEN: return par_bit == (^data);
      PARITY_ODD:  return par_bit == (~^data);
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/serial_frame_rx_timer.sv
// Loadable down-counter; tick marks the cycle on which the loaded interval has elapsed.
module rx_bit_timer #(
  parameter int unsigned MaxCount = 4,
  parameter int unsigned Width    = $clog2(MaxCount + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             tick
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  // Loading N makes tick fire N cycles after the load cycle.
  assign tick = (cnt_q == Width'(1));

endmodule

// File: rtl/serial_frame_rx.sv
// Oversampled serial frame receiver with a one-entry valid/ready output register.
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int unsigned DATA_LEN     = 7,
  parameter int unsigned PARITY_MODE  = 1,
  parameter int unsigned STOP_LEN     = 1,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                channel_in,
  output logic [DATA_LEN-1:0] data_out,
  output logic                valid,
  input  logic                ready,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun,
  output logic                busy
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned IW = $clog2(DATA_LEN + 1);

  logic                sync_q, sync_d, prev;
  rx_state_e           state;
  logic [IW-1:0]       bit_idx;
  logic                stop_idx;
  logic [DATA_LEN-1:0] shift;
  logic                par_err_r, frm_err_r;
  logic                start_edge, stop_bad;
  logic                tmr_load, tick;
  logic [TW-1:0]       tmr_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      sync_d <= 1'b0;
      prev   <= 1'b0;
    end else begin
      sync_q <= channel_in;
      sync_d <= sync_q;
      prev   <= sync_d;
    end
  end

  assign start_edge = ~prev & sync_d;
  assign stop_bad   = frm_err_r | ~sync_d;
  assign busy       = (state != StIdle);

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TW'(CLKS_PER_BIT);
    if (state == StIdle) begin
      if (start_edge) begin
        tmr_load = 1'b1;
        tmr_val  = TW'(CLKS_PER_BIT / 2);
      end
    end else if (tick) begin
      tmr_load = 1'b1;
    end
  end

  rx_bit_timer #(
    .MaxCount(CLKS_PER_BIT),
    .Width   (TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      par_err_r  <= 1'b0;
      frm_err_r  <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (valid && ready) valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start_edge) state <= StStart;
        end
        StStart: begin
          if (tick) begin
            state     <= sync_d ? StData : StIdle;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            par_err_r <= 1'b0;
            frm_err_r <= 1'b0;
          end
        end
        StData: begin
          if (tick) begin
            // LSB arrives first, so shift right and let it settle at bit 0.
            shift <= DATA_LEN'({sync_d, shift} >> 1);
            if (bit_idx == IW'(DATA_LEN - 1)) begin
              bit_idx <= '0;
              state   <= (PARITY_MODE == PARITY_NONE) ? StStop : StParity;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end
        StParity: begin
          if (tick) begin
            par_err_r <= ~parity_ok(32'(shift), sync_d, PARITY_MODE);
            state     <= StStop;
          end
        end
        StStop: begin
          if (tick) begin
            if (stop_idx == 1'(STOP_LEN - 1)) begin
              if (!valid || ready) begin
                data_out   <= shift;
                parity_err <= par_err_r;
                frame_err  <= stop_bad;
                valid      <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              stop_idx  <= 1'b0;
              frm_err_r <= 1'b0;
              state     <= StIdle;
            end else begin
              stop_idx  <= 1'b1;
              frm_err_r <= stop_bad;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench: two receiver configurations driven with directed and random frames.
module tb_serial_frame_rx;

  typedef struct {
    logic [31:0] data;
    logic        perr;
    logic        ferr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ch  [2];
  logic rdy [2];
  logic [6:0] d0;
  logic [7:0] d1;
  logic [31:0] dout [2];
  logic vld [2], perr [2], ferr [2], ov [2], bsy [2];

  int len   [2] = '{7, 8};
  int mode  [2] = '{1, 2};
  int nstop [2] = '{1, 2};
  int cpb   [2] = '{4, 16};

  exp_t q0[$], q1[$];
  int   pending [2] = '{0, 0};
  int   ov_exp  [2] = '{0, 0};
  int   ov_seen [2] = '{0, 0};
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  serial_frame_rx u_dut0 (
    .clk(clk), .rst(rst), .channel_in(ch[0]), .data_out(d0), .valid(vld[0]),
    .ready(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ov[0]), .busy(bsy[0])
  );

  serial_frame_rx #(
    .DATA_LEN(8), .PARITY_MODE(2), .STOP_LEN(2), .CLKS_PER_BIT(16)
  ) u_dut1 (
    .clk(clk), .rst(rst), .channel_in(ch[1]), .data_out(d1), .valid(vld[1]),
    .ready(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ov[1]), .busy(bsy[1])
  );

  assign dout[0] = 32'(d0);
  assign dout[1] = 32'(d1);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every accepted word is compared against the oldest expectation.
  initial forever begin
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      if (ov[u] === 1'b1) ov_seen[u]++;
      if (vld[u] === 1'b1 && rdy[u] === 1'b1) begin
        exp_t e;
        if ((u == 0 ? q0.size() : q1.size()) == 0) begin
          check($sformatf("unexpected_word_dut%0d", u), dout[u], 32'hxxxx_xxxx);
        end else begin
          e = (u == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("data_dut%0d", u), dout[u], e.data);
          check($sformatf("parity_err_dut%0d", u), 32'(perr[u]), 32'(e.perr));
          check($sformatf("frame_err_dut%0d", u), 32'(ferr[u]), 32'(e.ferr));
        end
      end
    end
  end

  task automatic drive_bit(input int u, input logic b);
    ch[u] = b;
    repeat (cpb[u]) @(negedge clk);
  endtask

  // Reference model: expected word, flags and overrun from the frame contents alone.
  task automatic send(input int u, input logic [31:0] data, input bit flip,
                      input logic [1:0] stop_mask);
    logic [63:0] one = 64'd1;
    logic [31:0] d;
    logic        rule, pbit;
    exp_t        e;
    d        = data & 32'((one << len[u]) - 1);
    rule     = (mode[u] == 1) ? (^d) : (~^d);
    pbit     = rule ^ flip;
    e.data   = d;
    e.perr   = (mode[u] != 0) && flip;
    e.ferr   = (nstop[u] == 1) ? !stop_mask[0] : !(&stop_mask);
    if (pending[u] != 0 && !rdy[u]) begin
      ov_exp[u]++;
    end else begin
      if (u == 0) q0.push_back(e);
      else q1.push_back(e);
      pending[u] = rdy[u] ? 0 : 1;
    end
    drive_bit(u, 1'b1);
    for (int i = 0; i < len[u]; i++) drive_bit(u, d[i]);
    if (mode[u] != 0) drive_bit(u, pbit);
    for (int i = 0; i < nstop[u]; i++) drive_bit(u, stop_mask[i]);
    ch[u] = 1'b0;
    repeat (2 * cpb[u]) @(negedge clk);
  endtask

  task automatic set_ready(input int u, input logic r);
    @(posedge clk);
    #1 rdy[u] = r;
    if (r) pending[u] = 0;
  endtask

  task automatic check_reset_state(input string tag);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("%s_data_dut%0d", tag, u), dout[u], 32'd0);
      check($sformatf("%s_valid_dut%0d", tag, u), 32'(vld[u]), 32'd0);
      check($sformatf("%s_flags_dut%0d", tag, u), {29'd0, perr[u], ferr[u], ov[u]}, 32'd0);
      check($sformatf("%s_busy_dut%0d", tag, u), 32'(bsy[u]), 32'd0);
    end
  endtask

  initial begin
    ch[0] = 1'b0; ch[1] = 1'b0;
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);

    // Clean frame, then bad parity; odd-parity unit with a correct parity bit.
    send(0, 32'h5A, 1'b0, 2'b11);
    check("valid_one_cycle", 32'(vld[0]), 32'd0);
    send(0, 32'h5A, 1'b1, 2'b11);
    send(1, 32'h5A, 1'b0, 2'b11);

    // Framing error then a normal frame.
    send(0, 32'h33, 1'b0, 2'b10);
    send(0, 32'h01, 1'b0, 2'b11);

    // Held word with consumer stalled: second frame is dropped.
    set_ready(0, 1'b0);
    @(negedge clk);
    send(0, 32'h11, 1'b0, 2'b11);
    send(0, 32'h22, 1'b0, 2'b11);
    check("held_data", dout[0], 32'h11);
    check("held_valid", 32'(vld[0]), 32'd1);
    check("overrun_count", 32'(ov_seen[0]), 32'(ov_exp[0]));
    set_ready(0, 1'b1);
    repeat (3) @(negedge clk);
    check("valid_drop_after_ready", 32'(vld[0]), 32'd0);

    // Single-clock glitch must not start a frame.
    ch[0] = 1'b1;
    @(negedge clk);
    ch[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy", 32'(bsy[0]), 32'd0);

    // Reset in the middle of the data bits.
    drive_bit(0, 1'b1);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
    check("mid_frame_busy", 32'(bsy[0]), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    ch[0] = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    send(0, 32'h7F, 1'b0, 2'b11);

    // Second stop bit low on the two-stop unit, then back-to-back traffic.
    send(1, 32'hA5, 1'b0, 2'b01);
    send(1, 32'h3C, 1'b0, 2'b11);
    send(1, 32'hC3, 1'b1, 2'b11);

    for (int k = 0; k < 24; k++) begin
      int u;
      logic [1:0] sm;
      u  = k % 2;
      sm = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      send(u, $urandom, ($urandom_range(0, 3) == 0), sm);
    end

    repeat (50) @(negedge clk);
    check("overrun_total_dut0", 32'(ov_seen[0]), 32'(ov_exp[0]));
    check("overrun_total_dut1", 32'(ov_seen[1]), 32'(ov_exp[1]));
    check("drain_dut0", 32'(q0.size()), 32'd0);
    check("drain_dut1", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
